muldiv_ctrl: RTL and testbench

Sequencer for the HI/LO unit of the MIPS core. It accepts one multiply/divide/move-to-HI/LO request at a time from the execute stage and drives the shared pipelined multiplier (operands plus signed flag, 64-bit product back) and the iterative divider (start/done handshake). It owns the architectural HI and LO registers and raises busy so the pipeline stalls HI/LO consumers. It also discards in-flight work on a pipeline flush.

---
 rtl/muldiv_ctrl_if.sv | 31 +++
 rtl/muldiv_ctrl.sv | 82 ++++++++
 tb/tb_muldiv_ctrl.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/muldiv_ctrl_if.sv
// muldiv_ctrl_if: request, multiplier, divider and HI/LO signals of the HI/LO unit.
interface muldiv_ctrl_if;
  logic        req_valid;
  logic [2:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        flush;
  logic        busy;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic        mul_signed;
  logic [63:0] mul_p;
  logic        div_start;
  logic        div_signed;
  logic [31:0] div_a;
  logic [31:0] div_b;
  logic        div_cancel;
  logic        div_done;
  logic [31:0] div_q;
  logic [31:0] div_r;
  logic [31:0] hi;
  logic [31:0] lo;
  modport master (
    output req_valid, req_op, req_a, req_b, flush, mul_p, div_done, div_q, div_r,
    input  busy, mul_a, mul_b, mul_signed, div_start, div_signed, div_a, div_b, div_cancel, hi, lo
  );
  modport slave (
    input  req_valid, req_op, req_a, req_b, flush, mul_p, div_done, div_q, div_r,
    output busy, mul_a, mul_b, mul_signed, div_start, div_signed, div_a, div_b, div_cancel, hi, lo
  );
endinterface

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: sequences MULT/DIV/MTHI/MTLO requests and owns the HI/LO registers.
module muldiv_ctrl #(
  parameter int MUL_LAT = 2,
  parameter int CNT_W   = 3
) (
  input logic         clk,
  input logic         resetn,
  muldiv_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, MUL_WAIT, DIV_WAIT} state_t;
  state_t           state;
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state          <= IDLE;
      cnt            <= '0;
      bus.busy       <= 1'b0;
      bus.hi         <= '0;
      bus.lo         <= '0;
      bus.mul_a      <= '0;
      bus.mul_b      <= '0;
      bus.mul_signed <= 1'b0;
      bus.div_a      <= '0;
      bus.div_b      <= '0;
      bus.div_signed <= 1'b0;
      bus.div_start  <= 1'b0;
      bus.div_cancel <= 1'b0;
    end else begin
      bus.div_start  <= 1'b0;
      bus.div_cancel <= 1'b0;
      case (state)
        IDLE: if (bus.req_valid && !bus.flush) begin
          case (bus.req_op)
            3'd1, 3'd2: begin
              bus.mul_a      <= bus.req_a;
              bus.mul_b      <= bus.req_b;
              bus.mul_signed <= (bus.req_op == 3'd1);
              cnt            <= '0;
              state          <= MUL_WAIT;
              bus.busy       <= 1'b1;
            end
            3'd3, 3'd4: begin
              bus.div_a      <= bus.req_a;
              bus.div_b      <= bus.req_b;
              bus.div_signed <= (bus.req_op == 3'd3);
              bus.div_start  <= 1'b1;
              state          <= DIV_WAIT;
              bus.busy       <= 1'b1;
            end
            3'd5:    bus.hi <= bus.req_a;
            3'd6:    bus.lo <= bus.req_a;
            default: ;
          endcase
        end
        MUL_WAIT: if (bus.flush) begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end else if (cnt == CNT_W'(MUL_LAT)) begin
          {bus.hi, bus.lo} <= bus.mul_p;
          state            <= IDLE;
          bus.busy         <= 1'b0;
        end else begin
          cnt <= cnt + 1'b1;
        end
        DIV_WAIT: if (bus.flush) begin
          bus.div_cancel <= 1'b1;
          state          <= IDLE;
          bus.busy       <= 1'b0;
        end else if (bus.div_done && !bus.div_start) begin
          bus.lo   <= bus.div_q;
          bus.hi   <= bus.div_r;
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed checks of muldiv_ctrl with a 2-stage multiplier model and a scripted divider.
module tb_muldiv_ctrl;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   vec = 0;
  int   miss = 0;
  logic [63:0] s1, s2, ea, eb;
  muldiv_ctrl_if bus ();
  muldiv_ctrl #(.MUL_LAT(2), .CNT_W(3)) dut (.clk(clk), .resetn(resetn), .bus(bus.slave));
  always #5 clk = ~clk;
  assign ea = bus.mul_signed ? {{32{bus.mul_a[31]}}, bus.mul_a} : {32'b0, bus.mul_a};
  assign eb = bus.mul_signed ? {{32{bus.mul_b[31]}}, bus.mul_b} : {32'b0, bus.mul_b};
  always_ff @(posedge clk) begin
    s1 <= ea * eb;
    s2 <= s1;
  end
  assign bus.mul_p = s2;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec++;
    assert (got === exp) else begin
      miss++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic req(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.req_valid = 1'b1;
    bus.req_op = op;
    bus.req_a = a;
    bus.req_b = b;
  endtask
  initial begin
    bus.req_valid = 0; bus.req_op = 0; bus.req_a = 0; bus.req_b = 0; bus.flush = 0;
    bus.div_done = 0; bus.div_q = 0; bus.div_r = 0;
    #2;
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_hilo", {bus.hi, bus.lo}, 64'd0);
    chk("rst_div_start", 64'(bus.div_start), 64'd0);
    chk("rst_mul_a", 64'(bus.mul_a), 64'd0);
    step();
    resetn = 1'b1;
    // MULT -2 * 3
    req(3'd1, 32'hFFFFFFFE, 32'd3);
    step();
    bus.req_valid = 0;
    chk("mult_busy0", 64'(bus.busy), 64'd1);
    chk("mult_signed", 64'(bus.mul_signed), 64'd1);
    chk("mult_a", 64'(bus.mul_a), 64'hFFFFFFFE);
    step();
    chk("mult_busy1", 64'(bus.busy), 64'd1);
    step();
    chk("mult_busy2", 64'(bus.busy), 64'd1);
    chk("mult_signed2", 64'(bus.mul_signed), 64'd1);
    step();
    chk("mult_busy3", 64'(bus.busy), 64'd0);
    chk("mult_hilo", {bus.hi, bus.lo}, 64'hFFFFFFFF_FFFFFFFA);
    // MULTU max * max
    req(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
    step();
    bus.req_valid = 0;
    chk("multu_signed", 64'(bus.mul_signed), 64'd0);
    step();
    step();
    chk("multu_busy", 64'(bus.busy), 64'd1);
    step();
    chk("multu_done", 64'(bus.busy), 64'd0);
    chk("multu_hilo", {bus.hi, bus.lo}, 64'hFFFFFFFE_00000001);
    // DIV -7 / 2, early div_done during start cycle must be ignored
    req(3'd3, 32'hFFFFFFF9, 32'd2);
    step();
    bus.req_valid = 0;
    chk("div_start", 64'(bus.div_start), 64'd1);
    chk("div_signed", 64'(bus.div_signed), 64'd1);
    chk("div_a", 64'(bus.div_a), 64'hFFFFFFF9);
    chk("div_b", 64'(bus.div_b), 64'd2);
    bus.div_done = 1; bus.div_q = 32'hDEAD; bus.div_r = 32'hBEEF;
    step();
    bus.div_done = 0;
    chk("div_start_pulse", 64'(bus.div_start), 64'd0);
    chk("div_early_done", {31'd0, bus.busy, bus.hi}, {31'd0, 1'b1, 32'hFFFFFFFE});
    for (int i = 0; i < 31; i++) step();
    chk("div_busy_wait", 64'(bus.busy), 64'd1);
    bus.div_done = 1; bus.div_q = 32'hFFFFFFFD; bus.div_r = 32'hFFFFFFFF;
    step();
    bus.div_done = 0;
    chk("div_busy_drop", 64'(bus.busy), 64'd0);
    chk("div_hilo", {bus.hi, bus.lo}, 64'hFFFFFFFF_FFFFFFFD);
    // MTHI then MTLO back-to-back
    req(3'd5, 32'h12345678, 32'd0);
    step();
    chk("mthi_hi", 64'(bus.hi), 64'h12345678);
    chk("mthi_lo", 64'(bus.lo), 64'hFFFFFFFD);
    chk("mthi_busy", 64'(bus.busy), 64'd0);
    req(3'd6, 32'h9ABCDEF0, 32'd0);
    step();
    bus.req_valid = 0;
    chk("mtlo_hilo", {bus.hi, bus.lo}, 64'h12345678_9ABCDEF0);
    chk("mtlo_busy", 64'(bus.busy), 64'd0);
    // DIVU flushed in flight, with div_done in the flush cycle
    req(3'd4, 32'd100, 32'd0);
    step();
    bus.req_valid = 0;
    chk("divu_signed", 64'(bus.div_signed), 64'd0);
    for (int i = 0; i < 8; i++) step();
    bus.flush = 1; bus.div_done = 1; bus.div_q = 32'h1111; bus.div_r = 32'h2222;
    step();
    bus.flush = 0; bus.div_done = 0;
    chk("flush_cancel", 64'(bus.div_cancel), 64'd1);
    chk("flush_busy", 64'(bus.busy), 64'd0);
    chk("flush_hilo", {bus.hi, bus.lo}, 64'h12345678_9ABCDEF0);
    step();
    chk("cancel_pulse", 64'(bus.div_cancel), 64'd0);
    bus.div_done = 1;
    step();
    bus.div_done = 0;
    chk("stray_done", {bus.hi, bus.lo}, 64'h12345678_9ABCDEF0);
    chk("stray_busy", 64'(bus.busy), 64'd0);
    // MULT with flush in the same cycle is dropped, MTHI with flush too
    req(3'd1, 32'd5, 32'd7);
    bus.flush = 1;
    step();
    chk("flush_req_busy", 64'(bus.busy), 64'd0);
    req(3'd5, 32'hCAFE, 32'd0);
    step();
    bus.flush = 0;
    chk("flush_mthi", 64'(bus.hi), 64'h12345678);
    // MULT accepted, second MULT while busy ignored
    req(3'd1, 32'd5, 32'd7);
    step();
    req(3'd1, 32'd2, 32'd2);
    step();
    bus.req_valid = 0;
    chk("busy_ign_a", 64'(bus.mul_a), 64'd5);
    step();
    chk("busy_ign_busy", 64'(bus.busy), 64'd1);
    step();
    chk("busy_ign_done", 64'(bus.busy), 64'd0);
    chk("busy_ign_hilo", {bus.hi, bus.lo}, 64'd35);
    // MULT flushed in MUL_WAIT
    req(3'd1, 32'd9, 32'd9);
    step();
    bus.req_valid = 0;
    bus.flush = 1;
    step();
    bus.flush = 0;
    chk("mflush_busy", 64'(bus.busy), 64'd0);
    step();
    step();
    chk("mflush_hilo", {bus.hi, bus.lo}, 64'd35);
    // reset mid-divide
    req(3'd3, 32'd10, 32'd3);
    step();
    bus.req_valid = 0;
    step();
    resetn = 0;
    #1;
    chk("amid_busy", 64'(bus.busy), 64'd0);
    chk("amid_hilo", {bus.hi, bus.lo}, 64'd0);
    chk("amid_cancel", 64'(bus.div_cancel), 64'd0);
    chk("amid_div_a", 64'(bus.div_a), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
